// File: rtl/pmt_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// pmt_pulse_conditioner
//
// Front end of the PMT photon-counting path. The asynchronous discriminator
// output is synchronized, edge-detected and turned into a single-cycle count
// strobe. A non-paralyzable dead-time models detector recovery, and a
// programmable gate window qualifies which photons reach the downstream
// counter.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   pmt_in       asynchronous PMT discriminator pulse
//   dead_cycles  hold-off length after each accepted edge (sampled on accept)
//   gate_len     gate window length in cycles (sampled on accepted gate_start)
//   gate_start   one-cycle request to open the gate window
//   count_en     one-cycle strobe per accepted in-gate photon
//   gate_open    high while the window is open
//   gate_done    one-cycle pulse when the window closes
//   reject_cnt   in-gate edges lost to dead-time, saturating at 255
//   busy         high while the gate FSM is in OPEN or DONE
// -----------------------------------------------------------------------------
module pmt_pulse_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DEAD_W      = 8,
   parameter int GATE_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pmt_in,
   input  logic [DEAD_W-1:0] dead_cycles,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              gate_start,
   output logic              count_en,
   output logic              gate_open,
   output logic              gate_done,
   output logic [7:0]        reject_cnt,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      OPEN,
      DONE
   } gate_state_t;

   localparam int                  BLANK_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [BLANK_W-1:0]  BLANK_INIT = BLANK_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist;
   logic                   strobe;
   logic [BLANK_W-1:0]     blank_cnt;
   logic [DEAD_W-1:0]      dead_cnt;
   logic [GATE_W-1:0]      gate_rem;
   gate_state_t            state;

   logic edge_raw;
   logic accept;
   logic reject;

   // Blanking hides the rising edge that a pin held high through reset would
   // otherwise produce once the cleared synchronizer refills.
   assign edge_raw = sync_q[SYNC_STAGES-1] & ~hist & (blank_cnt == '0);
   assign accept   = strobe & (dead_cnt == '0);
   assign reject   = strobe & (dead_cnt != '0);

   // Synchronizer, history flop and registered edge strobe. Registering the
   // strobe gives the SYNC_STAGES+1 cycle pulse-to-count_en latency.
   always_ff @(posedge clk) begin
      // NOTE: every state element here is a flop, so only non-blocking
      // assignments are used; reset is sampled on the clock edge.
      if (reset) begin
         sync_q    <= '0;
         hist      <= 1'b0;
         strobe    <= 1'b0;
         blank_cnt <= BLANK_INIT;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pmt_in};
         hist   <= sync_q[SYNC_STAGES-1];
         strobe <= edge_raw;
         if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
         end
      end
   end

   // Dead-time: a rejected strobe does not reload the counter, and the
   // hold-off runs whether or not the gate is open.
   always_ff @(posedge clk) begin
      if (reset) begin
         dead_cnt <= '0;
         count_en <= 1'b0;
      end else begin
         count_en <= accept & gate_open;
         if (accept) begin
            dead_cnt <= dead_cycles;
         end else if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - 1'b1;
         end
      end
   end

   // Gate FSM with registered outputs; reject_cnt lives here because its
   // clear is tied to an accepted gate_start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         gate_rem   <= '0;
         gate_open  <= 1'b0;
         gate_done  <= 1'b0;
         busy       <= 1'b0;
         reject_cnt <= '0;
      end else begin
         gate_done <= 1'b0;
         if (reject && gate_open && (reject_cnt != 8'hFF)) begin
            reject_cnt <= reject_cnt + 8'd1;
         end
         case (state)
            IDLE: begin
               if (gate_start) begin
                  reject_cnt <= '0;
                  busy       <= 1'b1;
                  if (gate_len != '0) begin
                     state     <= OPEN;
                     gate_rem  <= gate_len;
                     gate_open <= 1'b1;
                  end else begin
                     state     <= DONE;
                     gate_done <= 1'b1;
                  end
               end
            end
            OPEN: begin
               gate_rem <= gate_rem - 1'b1;
               if (gate_rem == GATE_W'(1)) begin
                  state     <= DONE;
                  gate_open <= 1'b0;
                  gate_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               gate_open <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pmt_pulse_conditioner.md
# pmt_pulse_conditioner

Front-end stage of the PMT photon-counting path. Takes the raw, asynchronous PMT discriminator output and turns each photon pulse into a single-cycle, clock-synchronous count strobe. Applies a programmable detector dead-time and a programmable counting gate window. `count_en` drives the enable input of the downstream 8-bit up-counter, so the counter advances exactly once per accepted photon inside the gate.

## Interface
Parameters:
- `SYNC_STAGES`, 2: number of synchronizer flops on `pmt_in` (legal values 2–4).
- `DEAD_W`, 8: width of `dead_cycles`.
- `GATE_W`, 16: width of `gate_len`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `pmt_in` in 1: asynchronous PMT discriminator pulse.
- `dead_cycles` in DEAD_W: hold-off length in cycles after each accepted edge. Sampled when an edge is accepted.
- `gate_len` in GATE_W: gate window length in cycles. Sampled when `gate_start` is accepted.
- `gate_start` in 1: one-cycle request to open the gate window.
- `count_en` out 1: one-cycle strobe per accepted in-gate photon.
- `gate_open` out 1: high while the window is open.
- `gate_done` out 1: one-cycle pulse when the window closes.
- `reject_cnt` out 8: count of in-gate edges lost to dead-time. Saturates at 255.
- `busy` out 1: high in OPEN and DONE states.

## Operation
- **Synchronizer:** `pmt_in` passes through `SYNC_STAGES` flops, then one history flop. The edge strobe is `sync & ~hist`.
- **Post-reset blanking:** edge strobes are masked for `SYNC_STAGES+1` cycles after `reset` deasserts. A pin held high through reset therefore produces no count.
- **Dead-time:**
  - A strobe is accepted when `dead_cnt == 0`. Acceptance loads `dead_cnt <= dead_cycles`.
  - `dead_cnt` decrements each cycle while it is nonzero.
  - A strobe arriving while `dead_cnt != 0` is rejected. It does not reload the counter (non-paralyzable model).
  - `dead_cycles == 0` means no hold-off.
  - Dead-time runs regardless of gate state, because it models detector recovery.
- **count_en:** registered. Asserts one cycle after an accepted strobe, only if `gate_open` was high in the strobe cycle.
- **reject_cnt:** increments for each rejected strobe seen while `gate_open` is high. It saturates at 255, holds after the gate closes, and clears to 0 when `gate_start` is accepted.
- **Gate FSM** with states IDLE, OPEN, DONE:
  - IDLE → OPEN on `gate_start` with `gate_len != 0`. Loads `gate_rem <= gate_len`.
  - IDLE → DONE on `gate_start` with `gate_len == 0`. `gate_open` never asserts in this case.
  - OPEN: `gate_rem` decrements each cycle. When `gate_rem == 1` the FSM goes to DONE.
  - DONE: `gate_done = 1` for exactly one cycle, then IDLE.
  - `gate_start` in OPEN or DONE is ignored and has no effect.
- **Reset mid-operation:** the FSM returns to IDLE immediately. `gate_open` drops with no `gate_done` pulse. All counters clear.

## Timing
- **Reset values:** `count_en = 0`, `gate_open = 0`, `gate_done = 0`, `reject_cnt = 0`, `busy = 0`. Sync/history flops, `dead_cnt` and `gate_rem` are all 0. FSM is in IDLE.
- **Gate latency:** `gate_start` sampled at edge N gives `gate_open = 1` from edge N+1 for exactly `gate_len` cycles. `gate_done` is high in the cycle immediately after the last open cycle.
- **Photon latency:** if `pmt_in` is first sampled high at edge N, the strobe appears after edge N+SYNC_STAGES and `count_en` is high after edge N+SYNC_STAGES+1. Total latency is SYNC_STAGES+1 cycles; with default parameters, 3 cycles.
- **Gate qualification:** uses `gate_open` in the strobe cycle. A strobe in the last open cycle counts; a strobe in the DONE cycle does not.
- **Minimum accepted spacing:** `dead_cycles+1` cycles between strobes. The `pmt_in` high and low phases must each be at least 1 clk period to be seen.
- **Handshake with downstream:** none beyond the strobe. `count_en` is never high for two consecutive cycles. `gate_done` is the downstream latch/clear cue.

## Test plan
- **Reset blanking:** hold `pmt_in = 1` through reset and release reset → `count_en` stays 0 for 20 cycles.
- **Basic gate count:** `gate_len = 100`, `dead_cycles = 0`, 5 isolated 2-cycle pulses spaced 10 cycles, all inside the gate → 5 `count_en` strobes, each 3 cycles after its pulse, `reject_cnt = 0`. `gate_open` is high for exactly 100 cycles, followed by one `gate_done`.
- **Dead-time:** `dead_cycles = 4`, pulses spaced 3 cycles apart (8 pulses) in the gate → alternate pulses accepted, giving 4 `count_en` and `reject_cnt = 4`. Repeat with 6-cycle spacing → 8 `count_en`, `reject_cnt = 0`.
- **Gate boundary:** `gate_len = 10`. One strobe timed into the 10th open cycle → counted. One strobe timed into the `gate_done` cycle → not counted. Re-pulse `gate_start` during OPEN → ignored; window length unchanged.
- **Zero and saturation:**
  - `gate_len = 0` → `gate_done` one cycle after `gate_start`, `gate_open` never high.
  - 300 rejected strobes in the gate with `dead_cycles = 255` → `reject_cnt = 255`.
- **Reset mid-window:** assert `reset` at open cycle 5 of a 50-cycle gate → next cycle all outputs are 0, no `gate_done`, and a fresh `gate_start` behaves normally.
